// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants and result-entry type for the adder issue controller.
// ADDSUB_FLAGS_EN adds zero/overflow fields to the stored result entry.
package addsub_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 4;
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] s;
    logic                 c;
    logic [DEF_TAG_W-1:0] tag;
`ifdef ADDSUB_FLAGS_EN
    logic                 z;
    logic                 v;
`endif
  } res_entry_t;
endpackage

// File: rtl/addsub_res_fifo.sv
// addsub_res_fifo: synchronous result FIFO; head reads as zero while empty.
module addsub_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 37
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_din,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_dout,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_count = r_cnt;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= (w_push && !w_pop) ? r_cnt + 1'b1 : (w_pop && !w_push) ? r_cnt - 1'b1 : r_cnt;
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_din;
endmodule

// File: rtl/addsub_issue_ctrl.sv
// addsub_issue_ctrl: credit-based issue stage and result buffer for a registered adder/subtractor.
// ADDSUB_FLAGS_EN adds RES_Z (zero) and RES_V (signed overflow) outputs.
module addsub_issue_ctrl #(
  parameter int WIDTH = addsub_pkg::DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int TAG_W = addsub_pkg::DEF_TAG_W
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_ADD,
  input  logic [WIDTH-1:0] REQ_A,
  input  logic [WIDTH-1:0] REQ_B,
  input  logic [TAG_W-1:0] REQ_TAG,
  output logic             ADD_SCLR,
  output logic             ADD_CE,
  output logic             ADD_OP,
  output logic [WIDTH-1:0] ADD_A,
  output logic [WIDTH-1:0] ADD_B,
  input  logic [WIDTH-1:0] ADD_S,
  input  logic             ADD_C_OUT,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_S,
  output logic             RES_C,
`ifdef ADDSUB_FLAGS_EN
  output logic             RES_Z,
  output logic             RES_V,
`endif
  output logic [TAG_W-1:0] RES_TAG
);
  import addsub_pkg::*;
  localparam int CW = $clog2(DEPTH+1);
  logic             r_inflight;
  logic [TAG_W-1:0] r_tag;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_occ;
  logic             w_full;
  logic             w_empty;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  res_entry_t       w_wr;
  res_entry_t       w_head;
`ifdef ADDSUB_FLAGS_EN
  logic             r_op;
  logic             r_as;
  logic             r_bs;
  logic             w_sign;
`endif
  assign ADD_SCLR = ~RSTN;
  // The in-flight op holds a credit so its result always has a FIFO slot.
  assign w_occ     = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign REQ_READY = RSTN && (w_occ < (CW+1)'(DEPTH));
  assign w_issue   = REQ_VALID && REQ_READY;
  assign ADD_CE    = w_issue;
  assign ADD_OP    = REQ_ADD;
  assign ADD_A     = REQ_A;
  assign ADD_B     = REQ_B;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      r_inflight <= 1'b0;
      r_tag      <= '0;
`ifdef ADDSUB_FLAGS_EN
      r_op       <= 1'b0;
      r_as       <= 1'b0;
      r_bs       <= 1'b0;
`endif
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag <= REQ_TAG;
`ifdef ADDSUB_FLAGS_EN
        r_op  <= REQ_ADD;
        r_as  <= REQ_A[WIDTH-1];
        r_bs  <= REQ_B[WIDTH-1];
`endif
      end
    end
`ifdef ADDSUB_FLAGS_EN
  assign w_sign = ADD_S[WIDTH-1];
`endif
  always_comb begin
    w_wr     = '0;
    w_wr.s   = ADD_S;
    w_wr.c   = ADD_C_OUT;
    w_wr.tag = r_tag;
`ifdef ADDSUB_FLAGS_EN
    w_wr.z   = ADD_S == '0;
    w_wr.v   = (r_op == OP_ADD) ? (r_as == r_bs && w_sign != r_as) : (r_as != r_bs && w_sign != r_as);
`endif
  end
  assign w_pop  = RES_VALID && RES_READY;
  assign w_push = r_inflight && (!w_full || w_pop);
  addsub_res_fifo #(
    .DEPTH(DEPTH),
    .W($bits(res_entry_t))
  ) u_fifo (
    .clk(CLK),
    .rst_n(RSTN),
    .i_push(w_push),
    .i_din(w_wr),
    .i_pop(w_pop),
    .o_dout(w_head),
    .o_count(w_count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign RES_VALID = ~w_empty;
  assign RES_S     = w_head.s;
  assign RES_C     = w_head.c;
  assign RES_TAG   = w_head.tag;
`ifdef ADDSUB_FLAGS_EN
  assign RES_Z     = w_head.z;
  assign RES_V     = w_head.v;
`endif
endmodule

// File: tb/tb_addsub_issue_ctrl.sv
// tb_addsub_issue_ctrl: directed bench with a registered adder model driven by the controller.
// Flag checks are built when ADDSUB_FLAGS_EN is defined.
module tb_addsub_issue_ctrl;
  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_ADD = 1'b0;
  logic [31:0] REQ_A = '0;
  logic [31:0] REQ_B = '0;
  logic [3:0]  REQ_TAG = '0;
  logic        ADD_SCLR, ADD_CE, ADD_OP, ADD_C_OUT;
  logic [31:0] ADD_A, ADD_B, ADD_S;
  logic        RES_VALID, RES_C;
  logic        RES_READY = 1'b0;
  logic [31:0] RES_S;
  logic [3:0]  RES_TAG;
`ifdef ADDSUB_FLAGS_EN
  logic        RES_Z, RES_V;
`endif
  logic [32:0] r_add;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (ADD_SCLR) r_add <= '0;
    else if (ADD_CE) r_add <= ADD_OP ? {1'b0, ADD_A} + {1'b0, ADD_B} : {1'b0, ADD_A} - {1'b0, ADD_B};
  assign ADD_S     = r_add[31:0];
  assign ADD_C_OUT = r_add[32];

  addsub_issue_ctrl dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADD(REQ_ADD),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_TAG(REQ_TAG),
    .ADD_SCLR(ADD_SCLR), .ADD_CE(ADD_CE), .ADD_OP(ADD_OP), .ADD_A(ADD_A), .ADD_B(ADD_B),
    .ADD_S(ADD_S), .ADD_C_OUT(ADD_C_OUT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_S(RES_S), .RES_C(RES_C),
`ifdef ADDSUB_FLAGS_EN
    .RES_Z(RES_Z), .RES_V(RES_V),
`endif
    .RES_TAG(RES_TAG)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] s, input logic c, input logic [3:0] t);
    chk(tag, {RES_VALID, RES_C, RES_TAG, RES_S}, {1'b1, c, t, s});
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic add, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    REQ_VALID = 1'b1;
    REQ_ADD   = add;
    REQ_A     = a;
    REQ_B     = b;
    REQ_TAG   = t;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int acc;
    int got;
    logic [31:0] sa [32];
    logic [31:0] sb [32];
    logic        so [32];
    logic [32:0] m;
    // reset state
    #1 RSTN = 1'b0;
    #1;
    chk("rst_valid", RES_VALID, 0);
    chk("rst_req_ready", REQ_READY, 0);
    chk("rst_sclr", ADD_SCLR, 1);
    chk("rst_res_fields", {RES_C, RES_TAG, RES_S}, 0);
    tick;
    tick;
    RSTN = 1'b1;
    #1;
    chk("post_rst_ready", REQ_READY, 1);
    chk("post_rst_sclr", ADD_SCLR, 0);
    // single add wrapping to zero with carry
    RES_READY = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 4'hA);
    #1;
    chk("issue_ce", ADD_CE, 1);
    chk("issue_pass", {ADD_OP, ADD_A, ADD_B}, {1'b1, 32'hFFFF_FFFF, 32'h1});
    tick;
    REQ_VALID = 1'b0;
    #1;
    chk("lat_one_edge", RES_VALID, 0);
    chk("idle_ce", ADD_CE, 0);
    tick;
    chk_res("add_wrap", 32'h0, 1'b1, 4'hA);
    tick;
    chk("add_popped", RES_VALID, 0);
    // subtract with and without borrow, back to back
    drive(1'b0, 32'd5, 32'd7, 4'h1);
    tick;
    drive(1'b0, 32'd7, 32'd5, 4'h2);
    tick;
    REQ_VALID = 1'b0;
    #1;
    chk_res("sub_borrow", 32'hFFFF_FFFE, 1'b1, 4'h1);
    tick;
    chk_res("sub_noborrow", 32'h2, 1'b0, 4'h2);
    tick;
    chk("sub_popped", RES_VALID, 0);
    // backpressure: only DEPTH requests can be outstanding
    RES_READY = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(acc) * 32'h1000 + 32'd7, 32'(acc), 4'(acc));
      #1;
      if (REQ_READY) acc++;
      tick;
    end
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", REQ_READY, 0);
    chk("bp_ce_low", ADD_CE, 0);
    RES_READY = 1'b1;
    #1;
    chk("bp_no_comb_ready", REQ_READY, 0);
    chk_res("bp_head0", 32'd7, 1'b0, 4'h0);
    tick;
    chk("bp_bubble_ready", REQ_READY, 1);
    got = 1;
    for (int i = 0; i < 20 && got < 6; i++) begin
      if (acc < 6) drive(1'b1, 32'(acc) * 32'h1000 + 32'd7, 32'(acc), 4'(acc));
      else REQ_VALID = 1'b0;
      #1;
      if (RES_VALID) begin
        chk_res("bp_order", 32'(got) * 32'h1001 + 32'd7, 1'b0, 4'(got));
        got++;
      end
      if (REQ_READY && acc < 6) acc++;
      tick;
    end
    REQ_VALID = 1'b0;
    chk("bp_delivered", got, 6);
    tick;
    chk("bp_drained", RES_VALID, 0);
    // streaming: one issue and one result per cycle
    for (int i = 0; i < 32; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
      so[i] = 1'($urandom_range(0, 1));
    end
    sa[0] = 32'h0; sb[0] = 32'h1; so[0] = 1'b0;
    sa[1] = 32'h8000_0000; sb[1] = 32'h8000_0000; so[1] = 1'b1;
    for (int c = 0; c < 34; c++) begin
      if (c < 32) drive(so[c], sa[c], sb[c], 4'(c));
      else REQ_VALID = 1'b0;
      #1;
      if (c < 32) chk("stream_ready", REQ_READY, 1);
      if (c < 2) chk("stream_fill", RES_VALID, 0);
      else begin
        m = so[c-2] ? {1'b0, sa[c-2]} + {1'b0, sb[c-2]} : {1'b0, sa[c-2]} - {1'b0, sb[c-2]};
        chk_res("stream_res", m[31:0], m[32], 4'(c - 2));
      end
      tick;
    end
    chk("stream_drained", RES_VALID, 0);
    // reset with two buffered results and one in flight
    RES_READY = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i), 32'h1, 4'(i));
      tick;
    end
    REQ_VALID = 1'b0;
    chk_res("pre_rst_head", 32'h2, 1'b0, 4'h1);
    RSTN = 1'b0;
    #1;
    chk("midrst_valid", RES_VALID, 0);
    chk("midrst_sclr", ADD_SCLR, 1);
    chk("midrst_ready", REQ_READY, 0);
    tick;
    RSTN = 1'b1;
    RES_READY = 1'b1;
    #1;
    chk("midrst_release_ready", REQ_READY, 1);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_rst_quiet", {RES_VALID, RES_C, RES_TAG, RES_S}, 0);
    end
    drive(1'b1, 32'd3, 32'd4, 4'h9);
    tick;
    REQ_VALID = 1'b0;
    #1;
    chk("post_rst_lat", RES_VALID, 0);
    tick;
    chk_res("post_rst_new", 32'd7, 1'b0, 4'h9);
    tick;
`ifdef ADDSUB_FLAGS_EN
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 4'h1);
    tick;
    drive(1'b0, 32'h8000_0000, 32'h1, 4'h2);
    tick;
    chk_res("flag_add_ovf", 32'h8000_0000, 1'b0, 4'h1);
    chk("flag_add_ovf_zv", {RES_Z, RES_V}, 2'b01);
    drive(1'b0, 32'd3, 32'd3, 4'h3);
    tick;
    REQ_VALID = 1'b0;
    chk_res("flag_sub_ovf", 32'h7FFF_FFFF, 1'b0, 4'h2);
    chk("flag_sub_ovf_zv", {RES_Z, RES_V}, 2'b01);
    tick;
    chk_res("flag_zero", 32'h0, 1'b0, 4'h3);
    chk("flag_zero_zv", {RES_Z, RES_V}, 2'b10);
    tick;
    chk("flag_drained", {RES_VALID, RES_Z, RES_V}, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
